// File: rtl/bit_stream_packer_pkg.sv
// Shared types and sizing helpers for the bit stream packer and the
// downstream population counter it feeds.
package bit_stream_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } packer_state_t;

   // Width of a bit counter able to hold 0..width inclusive
   function automatic int cnt_w(input int width);
      return $clog2(width) + 32'sd1;
   endfunction

endpackage

// File: rtl/bit_stream_packer_if.sv
// Serial-bit input and packed-word output bundle of the bit stream packer.
interface bit_stream_packer_if
   import bit_stream_pkg::*;
#(
   parameter int WIDTH = 8
) ();

   localparam int CW = cnt_w(WIDTH);

   logic             bit_val_i;
   logic             bit_i;
   logic             bit_last_i;
   logic [WIDTH-1:0] data_o;
   logic [CW-1:0]    data_mod_o;
   logic             data_val_o;

   modport master (
      output bit_val_i, bit_i, bit_last_i,
      input  data_o, data_mod_o, data_val_o
   );

   modport slave (
      input  bit_val_i, bit_i, bit_last_i,
      output data_o, data_mod_o, data_val_o
   );

endinterface

// File: rtl/bit_stream_packer.sv
// Packs a serial bit stream into WIDTH-bit words, emitting zero-padded
// partial words at end of frame so a downstream popcount stays exact.
module bit_stream_packer
   import bit_stream_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input logic                clk_i,
   input logic                arst_n_i,
   bit_stream_packer_if.slave bus
);

   localparam int CW = cnt_w(WIDTH);

   packer_state_t    state_r;
   logic [CW-1:0]    cnt_r;
   logic [WIDTH-1:0] shreg_r;
   logic [WIDTH-1:0] data_r;
   logic [CW-1:0]    data_mod_r;
   logic             data_val_r;

   logic [CW-1:0]    base_s;
   logic [CW-1:0]    pos_s;
   logic [WIDTH-1:0] word_s;
   logic             done_s;

   // Slot for the incoming bit, merged word, and word-completion decision
   always_comb begin
      base_s = '0;
      case (state_r)
         IDLE:    base_s = '0;
         FILL:    base_s = cnt_r;
         default: base_s = '0;
      endcase

      if (MSB_FIRST) begin
         pos_s = CW'(WIDTH - 1) - base_s;
      end else begin
         pos_s = base_s;
      end

      word_s = shreg_r;
      for (int i = 0; i < WIDTH; i++) begin
         if (CW'(i) == pos_s) begin
            word_s[i] = bus.bit_i;
         end else begin
            word_s[i] = shreg_r[i];
         end
      end

      if (bus.bit_val_i && (bus.bit_last_i || (base_s == CW'(WIDTH - 1)))) begin
         done_s = 1'b1;
      end else begin
         done_s = 1'b0;
      end
   end

   // Packer FSM: accumulate accepted bits, emit and clear on completion
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state_r    <= IDLE;
         cnt_r      <= '0;
         shreg_r    <= '0;
         data_r     <= '0;
         data_mod_r <= '0;
         data_val_r <= 1'b0;
      end else begin
         data_val_r <= 1'b0;
         if (done_s) begin
            data_r     <= word_s;
            data_mod_r <= base_s + CW'(1);
            data_val_r <= 1'b1;
            shreg_r    <= '0;
            cnt_r      <= '0;
            state_r    <= IDLE;
         end else if (bus.bit_val_i) begin
            shreg_r <= word_s;
            cnt_r   <= base_s + CW'(1);
            state_r <= FILL;
         end else begin
            shreg_r <= shreg_r;
            cnt_r   <= cnt_r;
            state_r <= state_r;
         end
      end
   end

   assign bus.data_o     = data_r;
   assign bus.data_mod_o = data_mod_r;
   assign bus.data_val_o = data_val_r;

endmodule

// File: tb/tb_bit_stream_packer.sv
// Drives one bit stream into an MSB-first and an LSB-first packer and checks
// both against a frame-level model plus hand-computed words.
module tb_bit_stream_packer;

   logic clk;
   logic arst_n;
   logic val;
   logic bi;
   logic lst;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   bit_stream_packer_if #(.WIDTH(8)) if_m ();
   bit_stream_packer_if #(.WIDTH(8)) if_l ();

   assign if_m.bit_val_i  = val;
   assign if_m.bit_i      = bi;
   assign if_m.bit_last_i = lst;
   assign if_l.bit_val_i  = val;
   assign if_l.bit_i      = bi;
   assign if_l.bit_last_i = lst;

   bit_stream_packer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
      .clk_i    (clk),
      .arst_n_i (arst_n),
      .bus      (if_m)
   );

   bit_stream_packer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
      .clk_i    (clk),
      .arst_n_i (arst_n),
      .bus      (if_l)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Frame-level model: collect accepted bits, build the word when it closes
   bit         q_bits[$];
   logic       exp_val;
   logic [7:0] exp_dm;
   logic [7:0] exp_dl;
   logic [3:0] exp_mod;

   function automatic logic [7:0] pack(input bit msb, input bit bits[$]);
      logic [7:0] r;
      r = 8'h00;
      foreach (bits[k]) begin
         if (msb) r[7 - k] = bits[k];
         else     r[k]     = bits[k];
      end
      return r;
   endfunction

   always @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         q_bits.delete();
         exp_val <= 1'b0;
         exp_dm  <= 8'h00;
         exp_dl  <= 8'h00;
         exp_mod <= 4'd0;
      end else begin
         exp_val <= 1'b0;
         if (val) begin
            q_bits.push_back(bi);
            if (lst || q_bits.size() == 8) begin
               exp_val <= 1'b1;
               exp_dm  <= pack(1'b1, q_bits);
               exp_dl  <= pack(1'b0, q_bits);
               exp_mod <= 4'(q_bits.size());
               q_bits.delete();
            end
         end
      end
   end

   typedef struct {
      logic [7:0] dm;
      logic [3:0] mm;
      logic [7:0] dl;
      logic [3:0] ml;
      int         cyc;
   } pulse_t;
   pulse_t plog[$];

   // Per-cycle comparison against the model, and a log of emitted words
   always @(negedge clk) begin
      if (arst_n) begin
         chk("val_m",  {31'd0, if_m.data_val_o}, {31'd0, exp_val});
         chk("val_l",  {31'd0, if_l.data_val_o}, {31'd0, exp_val});
         chk("data_m", {24'd0, if_m.data_o},     {24'd0, exp_dm});
         chk("data_l", {24'd0, if_l.data_o},     {24'd0, exp_dl});
         chk("mod_m",  {28'd0, if_m.data_mod_o}, {28'd0, exp_mod});
         chk("mod_l",  {28'd0, if_l.data_mod_o}, {28'd0, exp_mod});
         if (if_m.data_val_o) begin
            plog.push_back('{if_m.data_o, if_m.data_mod_o, if_l.data_o, if_l.data_mod_o, cyc});
         end
      end
   end

   int gtab[8] = '{2, 0, 3, 1, 0, 2, 1, 3};

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         val = 1'b0; bi = 1'b0; lst = 1'b0;
      end
   endtask

   task automatic send_bit(input logic b, input logic last, input int gap);
      repeat (gap) begin
         @(negedge clk);
         val = 1'b0; bi = ~bi; lst = 1'b1;
      end
      @(negedge clk);
      val = 1'b1; bi = b; lst = last;
   endtask

   // First bit sent is bits[n-1]
   task automatic send_word(input logic [7:0] bits, input int n, input bit last_at_end, input bit gaps);
      for (int k = 0; k < n; k++) begin
         send_bit(bits[n - 1 - k], last_at_end && (k == n - 1), gaps ? gtab[k % 8] : 0);
      end
   endtask

   task automatic chk_pulse(input string name, input int idx, input logic [7:0] dm, input logic [3:0] mm);
      if (plog.size() > idx) begin
         chk({name, "_data"}, {24'd0, plog[idx].dm}, {24'd0, dm});
         chk({name, "_mod"},  {28'd0, plog[idx].mm}, {28'd0, mm});
      end else begin
         chk({name, "_present"}, 32'(plog.size()), 32'(idx + 1));
      end
   endtask

   initial begin
      val = 1'b0; bi = 1'b0; lst = 1'b0;
      arst_n = 1'b1;
      #1 arst_n = 1'b0;
      #2;
      chk("rst_data", {24'd0, if_m.data_o}, 32'h0);
      chk("rst_mod",  {28'd0, if_m.data_mod_o}, 32'h0);
      chk("rst_val",  {31'd0, if_m.data_val_o}, 32'h0);
      idle(2);
      #2 arst_n = 1'b1;

      // Contiguous full word
      plog.delete();
      send_word(8'b1011_0010, 8, 1'b0, 1'b0);
      idle(3);
      chk("t1_count", 32'(plog.size()), 32'd1);
      chk_pulse("t1", 0, 8'hB2, 4'd8);
      if (plog.size() > 0) chk("t1_lsb", {24'd0, plog[0].dl}, 32'h4D);

      // Same word with gaps; bit_i toggles and bit_last_i is high while invalid
      plog.delete();
      send_word(8'b1011_0010, 8, 1'b0, 1'b1);
      idle(3);
      chk("t2_count", 32'(plog.size()), 32'd1);
      chk_pulse("t2", 0, 8'hB2, 4'd8);

      // Short frame followed back-to-back by a full word
      plog.delete();
      send_word(8'b0000_0111, 3, 1'b1, 1'b0);
      send_word(8'b1111_1111, 8, 1'b0, 1'b0);
      idle(3);
      chk("t3_count", 32'(plog.size()), 32'd2);
      chk_pulse("t3a", 0, 8'hE0, 4'd3);
      chk_pulse("t3b", 1, 8'hFF, 4'd8);
      if (plog.size() > 1) chk("t3_spacing", 32'(plog[1].cyc - plog[0].cyc), 32'd8);

      // Last on the 8th bit: exactly one word, then silence
      plog.delete();
      send_word(8'b0000_1111, 8, 1'b1, 1'b0);
      idle(12);
      chk("t4_count", 32'(plog.size()), 32'd1);
      chk_pulse("t4", 0, 8'h0F, 4'd8);

      // Mid-cycle reset after 5 bits discards the partial word
      plog.delete();
      send_word(8'b0001_1111, 5, 1'b0, 1'b0);
      @(negedge clk);
      val = 1'b0;
      #2 arst_n = 1'b0;
      #1;
      chk("t5_rst_data_m", {24'd0, if_m.data_o}, 32'h0);
      chk("t5_rst_data_l", {24'd0, if_l.data_o}, 32'h0);
      chk("t5_rst_mod",    {28'd0, if_m.data_mod_o}, 32'h0);
      chk("t5_rst_val",    {31'd0, if_m.data_val_o}, 32'h0);
      @(negedge clk);
      #2 arst_n = 1'b1;
      send_word(8'b1000_0001, 8, 1'b0, 1'b0);
      idle(3);
      chk("t5_count", 32'(plog.size()), 32'd1);
      chk_pulse("t5", 0, 8'h81, 4'd8);

      // LSB-first short frame, and its population count
      plog.delete();
      send_word(8'b0000_1000, 4, 1'b1, 1'b0);
      idle(3);
      chk("t6_count", 32'(plog.size()), 32'd1);
      chk_pulse("t6_msb", 0, 8'h80, 4'd4);
      if (plog.size() > 0) begin
         chk("t6_lsb_data", {24'd0, plog[0].dl}, 32'h01);
         chk("t6_lsb_mod",  {28'd0, plog[0].ml}, 32'd4);
         chk("t6_popcount", 32'($countones(plog[0].dl)), 32'd1);
      end

      // Single-bit frame from IDLE
      plog.delete();
      send_word(8'b0000_0001, 1, 1'b1, 1'b0);
      idle(3);
      chk("t7_count", 32'(plog.size()), 32'd1);
      chk_pulse("t7", 0, 8'h80, 4'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
